// File: rtl/disp_msg_ctrl_if.sv
// Signal bundle between the display message controller and its input devices / VGA top.
// slave is the controller side, master is the side driving device events.
interface disp_msg_ctrl_if;
  logic        dev_ok;
  logic        dev_err;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        key_enter;
  logic        rot_step;
  logic        rot_dir;
  logic        rot_press;
  logic        result_valid;
  logic [48:0] q_val;
  logic [48:0] i_val;
  logic        welcome_trig;
  logic [5:0]  print_line;
  logic [23:0] data_temp_disp;
  logic [48:0] q_val_op;
  logic [48:0] i_val_op;
  logic [23:0] key_val;
  logic [8:0]  angle_val;
  logic        calc_start;

  modport slave (
    input  dev_ok, dev_err, key_valid, key_digit, key_enter, rot_step, rot_dir, rot_press,
           result_valid, q_val, i_val,
    output welcome_trig, print_line, data_temp_disp, q_val_op, i_val_op, key_val, angle_val,
           calc_start
  );

  modport master (
    output dev_ok, dev_err, key_valid, key_digit, key_enter, rot_step, rot_dir, rot_press,
           result_valid, q_val, i_val,
    input  welcome_trig, print_line, data_temp_disp, q_val_op, i_val_op, key_val, angle_val,
           calc_start
  );
endinterface

// File: rtl/disp_msg_ctrl.sv
// Display message controller: sequences welcome, keypad entry, rotary angle entry, CORDIC
// calculation and result/error screens, with all outputs registered.
module disp_msg_ctrl #(
  parameter int unsigned WELCOME_CYC = 50000000,
  parameter int unsigned KEEP_CYC    = 100000000
) (
  input logic            clk,
  input logic            reset,
  disp_msg_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StWelcome, StWaitDev, StKey, StRot, StCalc, StResult, StErr
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  dcnt_q, dcnt_d;
  logic [23:0] disp_q, disp_d;
  logic [23:0] key_val_q, key_val_d;
  logic [8:0]  angle_q, angle_d;
  logic [48:0] q_op_q, q_op_d;
  logic [48:0] i_op_q, i_op_d;
  logic        calc_start_q, calc_start_d;
  logic        welcome_trig_q, welcome_trig_d;
  logic [5:0]  print_line_q, print_line_d;
  logic [8:0]  ang_cur, ang_next;

  // Angle wraps within 0..359 in both directions.
  always_comb begin
    ang_cur = disp_q[8:0];
    if (bus.rot_dir) begin
      ang_next = (ang_cur == 9'd359) ? 9'd0 : ang_cur + 9'd1;
    end else begin
      ang_next = (ang_cur == 9'd0) ? 9'd359 : ang_cur - 9'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dcnt_d       = dcnt_q;
    disp_d       = disp_q;
    key_val_d    = key_val_q;
    angle_d      = angle_q;
    q_op_d       = q_op_q;
    i_op_d       = i_op_q;
    calc_start_d = 1'b0;

    unique case (state_q)
      StWelcome: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == WELCOME_CYC - 1) state_d = StWaitDev;
      end
      StErr: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == KEEP_CYC - 1) state_d = StWaitDev;
      end
      default: begin
        if (bus.dev_err) begin
          state_d = StErr;
        end else if (!bus.dev_ok) begin
          state_d = StWaitDev;
        end else begin
          case (state_q)
            StWaitDev: begin
              state_d = StKey;
              disp_d  = '0;
              dcnt_d  = '0;
            end
            StKey: begin
              // Enter wins over a simultaneous digit.
              if (bus.key_enter && (dcnt_q != 3'd0)) begin
                key_val_d = disp_q;
                disp_d    = '0;
                state_d   = StRot;
              end else if (bus.key_valid) begin
                if (bus.key_digit > 4'd9) begin
                  state_d = StErr;
                end else if (dcnt_q < 3'd6) begin
                  disp_d = {disp_q[19:0], bus.key_digit};
                  dcnt_d = dcnt_q + 3'd1;
                end
              end
            end
            StRot: begin
              if (bus.rot_press) begin
                angle_d      = disp_q[8:0];
                calc_start_d = 1'b1;
                state_d      = StCalc;
              end else if (bus.rot_step) begin
                disp_d = {15'd0, ang_next};
              end
            end
            StCalc: begin
              if (bus.result_valid) begin
                q_op_d  = bus.q_val;
                i_op_d  = bus.i_val;
                state_d = StResult;
              end
            end
            StResult: begin
              cnt_d = cnt_q + 32'd1;
              if (cnt_q == KEEP_CYC - 1) begin
                state_d = StKey;
                disp_d  = '0;
                dcnt_d  = '0;
              end
            end
            default: ;
          endcase
        end
      end
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  // Screen selects are decoded from the next state so they register alongside it.
  always_comb begin
    print_line_d   = 6'b000000;
    welcome_trig_d = (state_d == StWelcome);
    unique case (state_d)
      StKey:         print_line_d = 6'b000101;
      StRot, StCalc: print_line_d = 6'b001001;
      StResult:      print_line_d = 6'b110001;
      StErr:         print_line_d = 6'b100010;
      default:       ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StWelcome;
      cnt_q          <= '0;
      dcnt_q         <= '0;
      disp_q         <= '0;
      key_val_q      <= '0;
      angle_q        <= '0;
      q_op_q         <= '0;
      i_op_q         <= '0;
      calc_start_q   <= 1'b0;
      welcome_trig_q <= 1'b1;
      print_line_q   <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      dcnt_q         <= dcnt_d;
      disp_q         <= disp_d;
      key_val_q      <= key_val_d;
      angle_q        <= angle_d;
      q_op_q         <= q_op_d;
      i_op_q         <= i_op_d;
      calc_start_q   <= calc_start_d;
      welcome_trig_q <= welcome_trig_d;
      print_line_q   <= print_line_d;
    end
  end

  assign bus.welcome_trig   = welcome_trig_q;
  assign bus.print_line     = print_line_q;
  assign bus.data_temp_disp = disp_q;
  assign bus.q_val_op       = q_op_q;
  assign bus.i_val_op       = i_op_q;
  assign bus.key_val        = key_val_q;
  assign bus.angle_val      = angle_q;
  assign bus.calc_start     = calc_start_q;

endmodule

// File: doc/disp_msg_ctrl.md
DISP_MSG_CTRL -- requirements
Module: disp_msg_ctrl

Interface
REQ-001 The block SHALL expose these parameters: WELCOME_CYC, 50000000, number of clk cycles the welcome screen is held; KEEP_CYC, 100000000, number of clk cycles a result or error screen is held.
REQ-002 The block SHALL have these ports, one per line:
- clk  in  1  system clock; single clock domain, rising edge.
- reset  in  1  asynchronous, active-low reset.
- dev_ok  in  1  input device detected (level).
- dev_err  in  1  device or link error (single-cycle pulse).
- key_valid  in  1  keypad digit strobe (single-cycle pulse).
- key_digit  in  4  keypad code, qualified by key_valid.
- key_enter  in  1  keypad enter (single-cycle pulse).
- rot_step  in  1  rotary detent (single-cycle pulse).
- rot_dir  in  1  1 = clockwise, 0 = counter-clockwise; qualified by rot_step.
- rot_press  in  1  rotary push (single-cycle pulse).
- result_valid  in  1  CORDIC result strobe.
- q_val  in  49  CORDIC Q result.
- i_val  in  49  CORDIC I result.
- welcome_trig  out  1  welcome screen select for the VGA top.
- print_line  out  6  bits 0..5: ip_device_on, error_on, value_enter_key_on, value_enter_rot_on, result_on, keep_disp_msg.
- data_temp_disp  out  24  value currently being shown.
- q_val_op  out  49  latched Q result for display.
- i_val_op  out  49  latched I result for display.
- key_val  out  24  committed keypad value, 6 BCD digits.
- angle_val  out  9  committed angle, binary, range 0..359.
- calc_start  out  1  single-cycle CORDIC start pulse.

Function
REQ-003 The block SHALL register all outputs; the output values are a function of the state register and the data registers only.
REQ-004 The FSM SHALL have the states WELCOME, WAIT_DEV, KEY, ROT, CALC, RESULT and ERR.
REQ-005 print_line SHALL take these values per state:
- WELCOME and WAIT_DEV: 000000
- KEY: 000101
- ROT and CALC: 001001
- RESULT: 110001
- ERR: 100010
REQ-006 welcome_trig SHALL be 1 only in WELCOME.
REQ-007 WELCOME SHALL last exactly WELCOME_CYC cycles after reset release and then go to WAIT_DEV; all inputs are ignored while in WELCOME.
REQ-008 WAIT_DEV SHALL go to KEY on the first cycle with dev_ok=1, clearing data_temp_disp and the digit count.
REQ-009 In KEY, key_valid with key_digit<=9 and digit count<6 SHALL update data_temp_disp to {data_temp_disp[19:0], key_digit} and increment the digit count.
REQ-010 In KEY, key_valid with key_digit<=9 and digit count=6 SHALL be dropped with no change.
REQ-011 In KEY, key_valid with key_digit>9 SHALL go to ERR.
REQ-012 In KEY, key_enter with digit count>=1 SHALL latch key_val=data_temp_disp, clear data_temp_disp and go to ROT; key_enter with digit count=0 SHALL be ignored.
REQ-013 In KEY, when key_enter and key_valid occur in the same cycle, key_enter SHALL take effect and the digit SHALL be dropped.
REQ-014 In ROT, each rot_step SHALL change data_temp_disp[8:0] by +1 (rot_dir=1) or -1 (rot_dir=0), wrapping 359->0 and 0->359; data_temp_disp[23:9] SHALL stay 0.
REQ-015 In ROT, rot_press SHALL latch angle_val=data_temp_disp[8:0], pulse calc_start for exactly one cycle and go to CALC; if rot_step occurs in the same cycle, the step SHALL be dropped.
REQ-016 In CALC, result_valid SHALL latch q_val_op=q_val and i_val_op=i_val and go to RESULT, with a 0-cycle input-to-register latency (captured on the same edge).
REQ-017 RESULT and ERR SHALL each hold for exactly KEEP_CYC cycles; RESULT then goes to KEY with data_temp_disp cleared, and ERR then goes to WAIT_DEV.
REQ-018 q_val_op and i_val_op SHALL retain their values until the next result_valid capture.
REQ-019 In any state except WELCOME and ERR, dev_err SHALL go to ERR with priority over all other inputs in that cycle; dev_err in ERR SHALL NOT restart the hold timer.
REQ-020 In any state except WELCOME and ERR, dev_ok=0 SHALL return the FSM to WAIT_DEV.
REQ-021 result_valid outside CALC SHALL be ignored.

Reset
REQ-022 On reset=0, asynchronously: state=WELCOME, welcome_trig=1, print_line=0, data_temp_disp=0, q_val_op=0, i_val_op=0, key_val=0, angle_val=0, calc_start=0, all counters=0.
REQ-023 Reset mid-operation, including mid-CALC, SHALL discard any pending result; the WELCOME timing SHALL restart from reset release.

Verification (WELCOME_CYC=4, KEEP_CYC=3)
REQ-024 Release reset with dev_ok=1 -> welcome_trig=1 for exactly 4 cycles, then 1 cycle in WAIT_DEV, then print_line=000101.
REQ-025 In KEY, enter digits 1..7 then key_enter -> data_temp_disp steps to 0x123456, the 7th digit is dropped, key_val=0x123456, print_line=001001.
REQ-026 In ROT at angle 0, apply ccw, ccw, cw, cw, cw -> angle 359, 358, 359, 0, 1; then rot_press -> angle_val=1 and calc_start high for exactly 1 cycle.
REQ-027 In CALC, assert result_valid with q_val=49'h1, i_val=49'h2 -> q_val_op=1, i_val_op=2, print_line=110001 for 3 cycles, then KEY with data_temp_disp=0.
REQ-028 In KEY, key_digit=0xA -> ERR (print_line=100010) for 3 cycles; a dev_err pulse during ERR does not extend the hold; then WAIT_DEV.
REQ-029 Assert reset during CALC, then release and pulse result_valid -> outputs equal the REQ-022 values and q_val_op stays 0.
